// File: rtl/bingo_call_matcher.sv
// Pairs keypad digits into called numbers 01..99 and scans a fixed 3x3 card one cell per cycle.
// Optional duplicate-call history is enabled by defining BINGO_CALL_HISTORY_EN.
module bingo_call_matcher #(
  parameter logic [62:0] CARD = 63'h0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_game,
  input  logic [1:0] num_count,
  input  logic [7:0] cascade_reg,
  output logic [8:0] marks,
  output logic [6:0] called_num,
  output logic       call_valid,
  output logic       call_hit,
  output logic       dup_call,
  output logic       line_found,
  output logic       bingo,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, DIG0, DIG1, SCAN, DONE, WIN} state_t;
  state_t state, state_nx;

  logic [1:0] num_count_q;
  logic [3:0] idx;
  logic       hit_acc, line_q, bingo_q;
  logic       key_ev, digit_ok, is_dup, accept;
  logic [7:0] num_w;
  logic [6:0] num;
  logic [8:0] cell_match;
  logic [7:0] lines;
  logic       any_line, all_marked;

  assign key_ev   = num_count != num_count_q;
  assign digit_ok = cascade_reg[3:0] <= 4'd9;
  assign num_w    = {4'd0, cascade_reg[7:4]} * 8'd10 + {4'd0, cascade_reg[3:0]};
  assign num      = num_w[6:0];

  for (genvar gi = 0; gi < 9; gi++) begin : g_cell
    assign cell_match[gi] = CARD[7*gi +: 7] == called_num;
  end

  assign lines = {marks[2] & marks[4] & marks[6], marks[0] & marks[4] & marks[8],
                  marks[2] & marks[5] & marks[8], marks[1] & marks[4] & marks[7],
                  marks[0] & marks[3] & marks[6], marks[6] & marks[7] & marks[8],
                  marks[3] & marks[4] & marks[5], marks[0] & marks[1] & marks[2]};
  assign any_line   = |lines;
  assign all_marked = &marks;
  assign accept     = (state == DIG1) && (state_nx == SCAN);

`ifdef BINGO_CALL_HISTORY_EN
  logic [99:0] hist;
  logic        dup_q, dup_now;

  assign is_dup  = (num < 7'd100) && hist[num];
  assign dup_now = start_game && (state == DIG1) && key_ev && digit_ok && (num != 7'd0) && is_dup;
  assign dup_call = dup_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist  <= '0;
      dup_q <= 1'b0;
    end else begin
      dup_q <= dup_now;
      if (accept) hist[num] <= 1'b1;
    end
  end
`else
  assign is_dup   = 1'b0;
  assign dup_call = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_game) state_nx = DIG0;
      DIG0: if (key_ev && digit_ok) state_nx = DIG1;
      DIG1: if (key_ev) state_nx = (!digit_ok || num == 7'd0 || is_dup) ? DIG0 : SCAN;
      SCAN: if (idx == 4'd8) state_nx = DONE;
      DONE: state_nx = all_marked ? WIN : DIG0;
      WIN:  state_nx = WIN;
      default: state_nx = IDLE;
    endcase
    // Dropping start_game abandons any pending digit or scan, but WIN is final.
    if (!start_game && state != WIN) state_nx = IDLE;
  end

  always_comb begin
    busy       = (state == SCAN) || (state == DONE);
    call_valid = state == DONE;
    call_hit   = (state == DONE) && hit_acc;
    line_found = line_q  | ((state == DONE) && any_line);
    bingo      = bingo_q | ((state == DONE) && all_marked);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      num_count_q <= num_count;
      called_num  <= '0;
      marks       <= '0;
      idx         <= '0;
      hit_acc     <= 1'b0;
      line_q      <= 1'b0;
      bingo_q     <= 1'b0;
    end else begin
      num_count_q <= num_count;
      if (accept) begin
        called_num <= num;
        idx        <= '0;
        hit_acc    <= 1'b0;
      end
      if (state == SCAN) begin
        idx <= idx + 4'd1;
        if (cell_match[idx]) begin
          marks[idx] <= 1'b1;
          hit_acc    <= 1'b1;
        end
      end
      if (state == DONE) begin
        line_q  <= line_q | any_line;
        bingo_q <= bingo_q | all_marked;
      end
    end
  end
endmodule

// File: tb/tb_bingo_call_matcher.sv
// Directed bench for bingo_call_matcher on a card holding 1..9 in row-major order.
module tb_bingo_call_matcher;
  localparam logic [62:0] CARD = {7'd9, 7'd8, 7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1};

  logic       clk = 1'b0;
  logic       rstn, start_game;
  logic [1:0] num_count;
  logic [7:0] cascade_reg;
  logic [8:0] marks;
  logic [6:0] called_num;
  logic       call_valid, call_hit, dup_call, line_found, bingo, busy;

  int errs = 0;
  int checks = 0;
  int pulses;

  bingo_call_matcher #(.CARD(CARD)) dut (
    .clk(clk), .rstn(rstn), .start_game(start_game), .num_count(num_count),
    .cascade_reg(cascade_reg), .marks(marks), .called_num(called_num),
    .call_valid(call_valid), .call_hit(call_hit), .dup_call(dup_call),
    .line_found(line_found), .bingo(bingo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Key change applied mid-cycle; returns 1ns after the edge that consumes it.
  task automatic press(input logic [3:0] d);
    @(negedge clk);
    cascade_reg = {cascade_reg[3:0], d};
    num_count   = num_count + 2'd1;
    step();
  endtask

  // Two digits, then wait until the DONE cycle (E+10).
  task automatic call(input logic [3:0] a, input logic [3:0] b);
    press(a);
    press(b);
    repeat (9) step();
  endtask

  task automatic count_pulses(input int n);
    pulses = 0;
    repeat (n) begin
      step();
      if (call_valid || dup_call) pulses++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_marks"}, 32'(marks), 32'h0);
    chk({tag, "_num"},   32'(called_num), 32'h0);
    chk({tag, "_pulse"}, 32'({call_valid, call_hit, dup_call}), 32'h0);
    chk({tag, "_flags"}, 32'({line_found, bingo, busy}), 32'h0);
  endtask

  initial begin
    rstn = 1'b0; start_game = 1'b0; num_count = 2'd0; cascade_reg = 8'h00;
    step(); step();
    chk_all_zero("rst");

    rstn = 1'b1; start_game = 1'b1;
    step(); step();

    // Call 05 with scan timing probes.
    press(0); press(5);
    chk("busy_e1", 32'(busy), 32'h1);
    repeat (4) step();
    chk("marks_e5", 32'(marks), 32'h000);
    step();
    chk("marks_e6", 32'(marks), 32'h010);
    repeat (4) step();
    chk("c05_valid", 32'({call_valid, call_hit}), 32'h3);
    chk("c05_num", 32'(called_num), 32'd5);
    step();
    chk("c05_after", 32'({call_valid, busy}), 32'h0);

    call(0, 1); step();
    call(0, 2);
    chk("c02_line", 32'(line_found), 32'h0);
    step();
    call(0, 3);
    chk("c03_marks", 32'(marks), 32'h017);
    chk("c03_line", 32'({line_found, bingo}), 32'h2);
    step();
    chk("line_sticky", 32'(line_found), 32'h1);

    // 00 is rejected silently.
    press(0); press(0);
    count_pulses(12);
    chk("c00_pulses", 32'(pulses), 32'h0);
    chk("c00_marks", 32'(marks), 32'h017);

    // A non-digit between digits cancels the first one.
    press(4); press(4'd12); press(7); press(3);
    repeat (9) step();
    chk("c73", 32'({call_valid, call_hit, called_num}), {30'h0, 2'b10} << 7 | 32'd73);
    step();

    call(4, 2);
    chk("c42", 32'({call_valid, call_hit, called_num}), 32'h100 | 32'd42);
    step();

`ifdef BINGO_CALL_HISTORY_EN
    press(0); press(5);
    chk("dup_e1", 32'({dup_call, call_valid}), 32'h2);
    count_pulses(12);
    chk("dup_no_valid", 32'(pulses), 32'h0);
`else
    call(0, 5);
    chk("redo05", 32'({call_valid, call_hit, dup_call}), 32'h6);
    step();
`endif

    call(0, 4); step();
    call(0, 6); step();
    call(0, 7); step();
    call(0, 8); step();
    call(0, 9);
    chk("bingo_done", 32'({call_valid, line_found, bingo}), 32'h7);
    chk("bingo_marks", 32'(marks), 32'h1FF);
    step();
    chk("win_idle", 32'({busy, bingo}), 32'h1);
    press(1); press(2);
    count_pulses(12);
    chk("win_pulses", 32'(pulses), 32'h0);
    chk("win_marks", 32'({marks, bingo}), {23'h0, 9'h1FF, 1'b1} >> 0 & 32'h3FF);

    // Reset while the scan sits at index 4.
    rstn = 1'b0; step(); rstn = 1'b1; step(); step();
    chk_all_zero("rst2");
    press(0); press(5);
    repeat (4) step();
    chk("scan4_busy", 32'(busy), 32'h1);
    @(negedge clk);
    rstn = 1'b0;
    step();
    chk_all_zero("rst_scan");
    rstn = 1'b1;
    count_pulses(12);
    chk("rst_quiet", 32'({pulses[7:0], marks}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
